exe_stage: RTL and testbench

Execute stage of the five-stage pipeline, directly downstream of instruction decode. Consumes the registered decode outputs (ALU control, operands, immediate, destination and write-back/memory controls), computes the ALU result, and registers result plus controls into the EXE/MEM boundary. Shifts run on an iterative one-bit-per-cycle shifter; while a shift is in flight the block raises `stall` to freeze PC and decode registers and issues bubbles into MEM.

---
 rtl/exe_pkg.sv | 45 ++++
 rtl/exe_stage_alu32.sv | 23 ++
 rtl/exe_stage.sv | 150 +++++++++++++++
 tb/tb_exe_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states,
// the EXE/MEM register bundle and the single-step shift helper.
package exe_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRA = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] b;
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic [4:0]  d;
   } mem_t;

   // A bubble writes nothing downstream: all controls and data cleared.
   localparam mem_t MEM_BUBBLE = '0;

   function automatic logic is_shift(input logic [2:0] aluc);
      return (aluc == ALU_SRA) || (aluc == ALU_SLL) || (aluc == ALU_SRL);
   endfunction

   function automatic logic [31:0] shift1(input logic [2:0] op, input logic [31:0] x);
      logic [31:0] r;
      case (op)
         ALU_SLL: r = {x[30:0], 1'b0};
         ALU_SRL: r = {1'b0, x[31:1]};
         default: r = {x[31], x[31:1]};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exe_stage_alu32.sv
// Combinational arithmetic/logic unit for the non-shift operations.
module alu32
   import exe_pkg::*;
(
   input  logic [2:0]  aluc,
   input  logic [31:0] a,
   input  logic [31:0] op2,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (aluc)
         ALU_ADD: result = a + op2;
         ALU_SUB: result = a - op2;
         ALU_AND: result = a & op2;
         ALU_OR:  result = a | op2;
         ALU_XOR: result = a ^ op2;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU plus iterative one-bit-per-cycle shifter feeding the
// EXE/MEM registers; multi-cycle shifts stall upstream and emit bubbles.
module exe_stage
   import exe_pkg::*;
(
   input  logic        clk,
   input  logic        clrn,
   input  logic [2:0]  exe_aluc,
   input  logic        exe_aluimm,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] exe_imm,
   input  logic        exe_shift,
   input  logic        exe_wreg,
   input  logic        exe_m2reg,
   input  logic        exe_wmem,
   input  logic [4:0]  exe_d,
   output logic [31:0] mem_alu,
   output logic [31:0] mem_b,
   output logic        mem_wreg,
   output logic        mem_m2reg,
   output logic        mem_wmem,
   output logic [4:0]  mem_d,
   output logic        stall
);

   state_t      state_reg, state_next;
   logic [31:0] shreg_reg, shreg_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic [2:0]  op_reg, op_next;
   logic [31:0] b_reg, b_next;
   logic        wreg_reg, wreg_next;
   logic        m2reg_reg, m2reg_next;
   logic        wmem_reg, wmem_next;
   logic [4:0]  d_reg, d_next;
   mem_t        mem_reg, mem_next;

   logic [31:0] op2;
   logic [31:0] alu_result;
   logic [4:0]  shamt;

   assign op2   = exe_aluimm ? exe_imm : b;
   assign shamt = exe_shift ? exe_imm[4:0] : a[4:0];

   alu32 u_alu (
      .aluc   (exe_aluc),
      .a      (a),
      .op2    (op2),
      .result (alu_result)
   );

   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      op_next    = op_reg;
      b_next     = b_reg;
      wreg_next  = wreg_reg;
      m2reg_next = m2reg_reg;
      wmem_next  = wmem_reg;
      d_next     = d_reg;
      mem_next   = MEM_BUBBLE;
      stall      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (is_shift(exe_aluc) && (shamt > 5'd1)) begin
               // First step happens now; cnt holds the steps still to go.
               stall      = 1'b1;
               shreg_next = shift1(exe_aluc, b);
               cnt_next   = shamt - 5'd1;
               op_next    = exe_aluc;
               b_next     = b;
               wreg_next  = exe_wreg;
               m2reg_next = exe_m2reg;
               wmem_next  = exe_wmem;
               d_next     = exe_d;
               state_next = ST_SHIFT;
            end else begin
               mem_next.b     = b;
               mem_next.wreg  = exe_wreg;
               mem_next.m2reg = exe_m2reg;
               mem_next.wmem  = exe_wmem;
               mem_next.d     = exe_d;
               if (!is_shift(exe_aluc))
                  mem_next.alu = alu_result;
               else if (shamt == 5'd0)
                  mem_next.alu = b;
               else
                  mem_next.alu = shift1(exe_aluc, b);
            end
         end
         ST_SHIFT: begin
            if (cnt_reg > 5'd1) begin
               stall      = 1'b1;
               shreg_next = shift1(op_reg, shreg_reg);
               cnt_next   = cnt_reg - 5'd1;
            end else begin
               mem_next.alu   = shift1(op_reg, shreg_reg);
               mem_next.b     = b_reg;
               mem_next.wreg  = wreg_reg;
               mem_next.m2reg = m2reg_reg;
               mem_next.wmem  = wmem_reg;
               mem_next.d     = d_reg;
               cnt_next       = 5'd0;
               state_next     = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Reset wins the same cycle so upstream is never frozen during reset.
      if (clrn)
         stall = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         state_reg <= ST_IDLE;
         shreg_reg <= '0;
         cnt_reg   <= '0;
         op_reg    <= '0;
         b_reg     <= '0;
         wreg_reg  <= 1'b0;
         m2reg_reg <= 1'b0;
         wmem_reg  <= 1'b0;
         d_reg     <= '0;
         mem_reg   <= MEM_BUBBLE;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         cnt_reg   <= cnt_next;
         op_reg    <= op_next;
         b_reg     <= b_next;
         wreg_reg  <= wreg_next;
         m2reg_reg <= m2reg_next;
         wmem_reg  <= wmem_next;
         d_reg     <= d_next;
         mem_reg   <= mem_next;
      end
   end

   assign mem_alu   = mem_reg.alu;
   assign mem_b     = mem_reg.b;
   assign mem_wreg  = mem_reg.wreg;
   assign mem_m2reg = mem_reg.m2reg;
   assign mem_wmem  = mem_reg.wmem;
   assign mem_d     = mem_reg.d;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, reset sequences
// and randomized transactions against a whole-operation reference model.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        clrn;
   logic [2:0]  exe_aluc;
   logic        exe_aluimm;
   logic [31:0] a, b, exe_imm;
   logic        exe_shift, exe_wreg, exe_m2reg, exe_wmem;
   logic [4:0]  exe_d;
   logic [31:0] mem_alu, mem_b;
   logic        mem_wreg, mem_m2reg, mem_wmem;
   logic [4:0]  mem_d;
   logic        stall;

   int n_checks = 0;
   int n_fail   = 0;

   exe_stage dut (
      .clk        (clk),
      .clrn       (clrn),
      .exe_aluc   (exe_aluc),
      .exe_aluimm (exe_aluimm),
      .a          (a),
      .b          (b),
      .exe_imm    (exe_imm),
      .exe_shift  (exe_shift),
      .exe_wreg   (exe_wreg),
      .exe_m2reg  (exe_m2reg),
      .exe_wmem   (exe_wmem),
      .exe_d      (exe_d),
      .mem_alu    (mem_alu),
      .mem_b      (mem_b),
      .mem_wreg   (mem_wreg),
      .mem_m2reg  (mem_m2reg),
      .mem_wmem   (mem_wmem),
      .mem_d      (mem_d),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  aluc;
      logic        aluimm;
      logic [31:0] va, vb, imm;
      logic        sh;
      logic        wreg, m2reg, wmem;
      logic [4:0]  d;
      logic [31:0] exp_alu;
      int          exp_stalls;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_ctl();
      return {mem_wreg, mem_m2reg, mem_wmem, mem_d};
   endfunction

   // Whole-operation reference: result and number of stall cycles.
   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] ra,
                                           input logic [31:0] rb, input logic [31:0] ri,
                                           input logic ai, input logic si);
      logic [31:0] o2;
      int n;
      o2 = ai ? ri : rb;
      n  = si ? int'(ri[4:0]) : int'(ra[4:0]);
      case (op)
         3'd0: return ra + o2;
         3'd1: return ra - o2;
         3'd2: return ra & o2;
         3'd3: return ra | o2;
         3'd4: return ra ^ o2;
         3'd5: return $unsigned($signed(rb) >>> n);
         3'd6: return rb << n;
         default: return rb >> n;
      endcase
   endfunction

   function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] ra,
                                     input logic [31:0] ri, input logic si);
      int n;
      n = si ? int'(ri[4:0]) : int'(ra[4:0]);
      return (op >= 3'd5 && n >= 2) ? n - 1 : 0;
   endfunction

   // Inputs must already be driven (at a falling edge). Walks the pipeline
   // until the result lands, counting stall cycles and checking bubbles.
   task automatic do_txn(input string tag, input logic [31:0] exp_alu, input int exp_stalls);
      int   stalls = 0;
      bit   bub_ok = 1'b1;
      bit   done = 1'b0;
      logic st;
      logic [31:0] exp_b;
      logic [7:0]  exp_ctl;
      exp_b   = b;
      exp_ctl = {exe_wreg, exe_m2reg, exe_wmem, exe_d};
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         st = stall;
         if (st) stalls++;
         @(posedge clk);
         #1;
         if (st) begin
            if (mem_alu !== 32'd0 || mem_b !== 32'd0 || mem_ctl() !== 8'd0) bub_ok = 1'b0;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) chk({tag, " timeout"}, 32'd1, 32'd0);
      chk({tag, " mem_alu"}, mem_alu, exp_alu);
      chk({tag, " mem_b"}, mem_b, exp_b);
      chk({tag, " ctl"}, {24'd0, mem_ctl()}, {24'd0, exp_ctl});
      chk({tag, " stalls"}, stalls, exp_stalls);
      chk({tag, " bubbles"}, {31'd0, bub_ok}, 32'd1);
      $display("txn %s aluc=%0d alu=%h stalls=%0d", tag, exe_aluc, mem_alu, stalls);
      @(negedge clk);
   endtask

   task automatic drive(input vec_t v);
      exe_aluc = v.aluc; exe_aluimm = v.aluimm; a = v.va; b = v.vb; exe_imm = v.imm;
      exe_shift = v.sh; exe_wreg = v.wreg; exe_m2reg = v.m2reg; exe_wmem = v.wmem; exe_d = v.d;
   endtask

   task automatic drive_random();
      exe_aluc = 3'($urandom_range(0, 7)); exe_aluimm = 1'($urandom); a = $urandom; b = $urandom;
      exe_imm = $urandom; exe_shift = 1'($urandom); exe_wreg = 1'($urandom);
      exe_m2reg = 1'($urandom); exe_wmem = 1'($urandom); exe_d = 5'($urandom);
   endtask

   initial begin
      tbl[0] = '{3'd0, 1'b1, 32'h5,        32'h0,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7,  32'h3,        0};
      tbl[1] = '{3'd1, 1'b0, 32'h10,       32'h11,       32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  32'hFFFFFFFF, 0};
      tbl[2] = '{3'd4, 1'b0, 32'h10,       32'h11,       32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  32'h1,        0};
      tbl[3] = '{3'd6, 1'b0, 32'h0,        32'h1,        32'h3,        1'b1, 1'b1, 1'b0, 1'b0, 5'd9,  32'h8,        2};
      tbl[4] = '{3'd5, 1'b0, 32'h1F,       32'h80000000, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFFFFFF, 30};
      tbl[5] = '{3'd5, 1'b0, 32'h20,       32'h12345678, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  32'h12345678, 0};
      tbl[6] = '{3'd2, 1'b1, 32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h00F000F0, 0};
      tbl[7] = '{3'd7, 1'b0, 32'h0,        32'h80000001, 32'h1,        1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h40000000, 0};
      tbl[8] = '{3'd3, 1'b0, 32'h0000FF00, 32'h00FF0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd1,  32'h00FFFF00, 0};
      tbl[9] = '{3'd6, 1'b1, 32'h0,        32'h3,        32'h1F,       1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  32'h80000000, 30};

      clrn = 1'b1;
      drive_random();
      exe_aluc = 3'd6; exe_shift = 1'b1; exe_imm[4:0] = 5'd20;

      // Reset with live inputs (a long shift request) must not stall.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         chk("reset stall", {31'd0, stall}, 32'd0);
         @(posedge clk); #1;
         chk("reset mem_alu", mem_alu, 32'd0);
         chk("reset mem_b", mem_b, 32'd0);
         chk("reset ctl", {24'd0, mem_ctl()}, 32'd0);
      end
      @(negedge clk);
      clrn = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i]);
         do_txn($sformatf("vec%0d", i), tbl[i].exp_alu, tbl[i].exp_stalls);
      end

      // Reset in the second shift cycle of an n=10 shift.
      exe_aluc = 3'd7; exe_aluimm = 1'b0; a = 32'd10; b = 32'hFFFFFFFF; exe_imm = 32'd0;
      exe_shift = 1'b0; exe_wreg = 1'b1; exe_m2reg = 1'b0; exe_wmem = 1'b1; exe_d = 5'd5;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk); #1;
      chk("midshift stall before reset", {31'd0, stall}, 32'd1);
      clrn = 1'b1; #1;
      chk("midshift stall in reset", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("midshift reset ctl", {24'd0, mem_ctl()}, 32'd0);
      @(negedge clk);
      clrn = 1'b0;
      exe_aluc = 3'd0; a = 32'd0; b = 32'd0; exe_wreg = 1'b0; exe_wmem = 1'b0; exe_d = 5'd0;
      begin
         bit quiet = 1'b1;
         for (int i = 0; i < 12; i++) begin
            #1;
            if (stall !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
            if (mem_alu !== 32'd0 || mem_b !== 32'd0 || mem_ctl() !== 8'd0) quiet = 1'b0;
            @(negedge clk);
         end
         chk("midshift no late write", {31'd0, quiet}, 32'd1);
      end
      a = 32'd1; b = 32'd2; exe_wreg = 1'b1; exe_d = 5'd6;
      do_txn("after_abort", 32'd3, 0);

      // Randomized back-to-back traffic.
      for (int i = 0; i < 150; i++) begin
         drive_random();
         do_txn($sformatf("rnd%0d", i),
                ref_alu(exe_aluc, a, b, exe_imm, exe_aluimm, exe_shift),
                ref_stalls(exe_aluc, a, exe_imm, exe_shift));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
